// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side master presenting words on a valid/ready stream
module fifo_stream_reader #(
  parameter int WIDTH_DATA = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic [WIDTH_DATA-1:0] fifo_data_i,
  output logic                  fifo_read_o,
  output logic [WIDTH_DATA-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      words_sent_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  state;
  logic                    busy_q;
  logic [1:0]              buf_cnt;
  logic                    inflight;
  logic [WIDTH_DATA-1:0]   buf_head;
  logic [WIDTH_DATA-1:0]   buf_tail;
  logic [CNT_W-1:0]        words_sent_q;

  logic                    pop;
  logic                    push;
  logic [2:0]              credit_sum;
  logic [2:0]              buf_cnt_next;

  // Stream side: head of the buffer is always what the consumer sees
  assign m_valid_o    = (buf_cnt != 2'd0) & ~rst_i;
  assign m_data_o     = buf_head;
  assign busy_o       = busy_q;
  assign words_sent_o = words_sent_q;

  // A word arrives from the FIFO one cycle after its read strobe
  assign pop  = m_valid_o & m_ready_i;
  assign push = inflight;

  // Words already committed (buffered + in flight) minus the one leaving now;
  // pop implies buf_cnt >= 1, so this never underflows
  assign credit_sum = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};

  // Read only while running and only when the buffer is sure to have room
  assign fifo_read_o = ~rst_i & (state == ST_RUN) & ~fifo_empty_i & (credit_sum < 3'd2);

  // Occupancy after this edge; one bit wider so an overflow would be visible
  assign buf_cnt_next = {1'b0, buf_cnt} + {2'b00, push} - {2'b00, pop};

  // Control FSM; busy is registered alongside the state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable_i) begin
            state  <= ST_RUN;
            busy_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!enable_i) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (enable_i) begin
            state <= ST_RUN;
          end else if (buf_cnt_next == 3'd0) begin
            // No read is issued in DRAIN, so an empty buffer after this edge
            // also means nothing is left in flight
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry in-order output buffer fed by the read pipeline
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_cnt  <= 2'd0;
      inflight <= 1'b0;
      buf_head <= '0;
      buf_tail <= '0;
    end else begin
      inflight <= fifo_read_o;
      buf_cnt  <= buf_cnt_next[1:0];
      case ({push, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) begin
            buf_head <= fifo_data_i;
          end else begin
            buf_tail <= fifo_data_i;
          end
        end
        2'b01: begin
          if (buf_cnt == 2'd2) begin
            buf_head <= buf_tail;
          end
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf_head <= fifo_data_i;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= fifo_data_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      words_sent_q <= '0;
    end else if (pop) begin
      words_sent_q <= words_sent_q + 1'b1;
    end
  end

  // The read credit must keep the buffer within its two entries
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (buf_cnt_next <= 3'd2);
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;
  localparam int W  = 8;
  localparam int CW = 4;
  localparam int FD = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data = '0;
  logic          fifo_read;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] words_sent;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // FIFO storage model: writes by the stimulus, reads registered by the clock
  logic [W-1:0] fifo_mem [FD];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  // Reference: every word pushed must come out once, in order
  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] model_cnt = '0;
  int outstanding = 0;
  bit prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  int read_log[$];
  int pop_log[$];

  fifo_stream_reader #(.WIDTH_DATA(W), .CNT_W(CW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .fifo_empty_i(fifo_empty),
    .fifo_data_i (fifo_data),
    .fifo_read_o (fifo_read),
    .m_data_o    (m_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .busy_o      (busy),
    .words_sent_o(words_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [W-1:0] w);
    fifo_mem[wr_ptr % FD] = w;
    wr_ptr++;
    exp_q.push_back(w);
  endtask

  // FIFO read port model
  always @(posedge clk) begin
    if (rst) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_read && (rd_ptr != wr_ptr)) begin
      fifo_data <= fifo_mem[rd_ptr % FD];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Monitor / scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      check("rst_read", {31'd0, fifo_read}, 32'd0);
      check("rst_valid", {31'd0, m_valid}, 32'd0);
      model_cnt   = '0;
      outstanding = 0;
      prev_stall  = 1'b0;
      exp_q.delete();
    end else begin
      check("words_sent", {28'd0, words_sent}, {28'd0, model_cnt});
      if (fifo_read) begin
        check("read_nonempty", {31'd0, !fifo_empty}, 32'd1);
        read_log.push_back(cyc);
      end
      if (prev_stall) begin
        check("stall_valid", {31'd0, m_valid}, 32'd1);
        check("stall_data", {24'd0, m_data}, {24'd0, prev_data});
      end
      if (m_valid && m_ready) begin
        check("pop_expected", exp_q.size() > 0, 32'd1);
        if (exp_q.size() > 0) check("pop_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        model_cnt = model_cnt + 1'b1;
        pop_log.push_back(cyc);
      end
      outstanding = outstanding + int'(fifo_read) - int'(m_valid && m_ready);
      check("credit", outstanding <= 2, 32'd1);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int c0;
    logic [W-1:0] first;

    // T1 reset with random inputs
    #1;
    for (int i = 0; i < 2; i++) begin
      enable  = 1'($urandom);
      m_ready = 1'($urandom);
      if ($urandom_range(0, 1) == 1) push(W'($urandom));
      tick(1);
    end
    rst = 1'b0; enable = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_valid", {31'd0, m_valid}, 32'd0);
    check("t1_read", {31'd0, fifo_read}, 32'd0);
    check("t1_words", {28'd0, words_sent}, 32'd0);
    tick(1);

    // T5 empty FIFO
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t5_read", {31'd0, fifo_read}, 32'd0);
      check("t5_valid", {31'd0, m_valid}, 32'd0);
      tick(1);
    end
    enable = 1'b0;
    tick(3);
    @(negedge clk);
    check("t5_idle", {31'd0, busy}, 32'd0);
    tick(1);

    // T2 basic stream timing
    push(8'h11); push(8'h22); push(8'h33);
    m_ready = 1'b1;
    tick(2);
    read_log.delete(); pop_log.delete();
    c0 = cyc;
    enable = 1'b1;
    tick(8);
    check("t2_nreads", read_log.size(), 32'd3);
    check("t2_npops", pop_log.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("t2_read_cyc", (i < read_log.size()) ? read_log[i] - c0 : -1, 1 + i);
      check("t2_pop_cyc", (i < pop_log.size()) ? pop_log[i] - c0 : -1, 3 + i);
    end
    @(negedge clk);
    check("t2_words", {28'd0, words_sent}, 32'd3);
    tick(1);

    // T3 backpressure
    m_ready = 1'b0;
    read_log.delete();
    first = W'($urandom);
    push(first);
    for (int i = 0; i < 4; i++) push(W'($urandom));
    tick(10);
    @(negedge clk);
    check("t3_nreads", read_log.size(), 32'd2);
    check("t3_valid", {31'd0, m_valid}, 32'd1);
    check("t3_head", {24'd0, m_data}, {24'd0, first});
    tick(1);
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    check("t3_delivered", exp_q.size(), 32'd0);
    check("t3_fifo_empty", wr_ptr - rd_ptr, 32'd0);

    // T4 drain
    m_ready = 1'b0;
    push(W'($urandom)); push(W'($urandom)); push(W'($urandom));
    tick(8);
    read_log.delete();
    enable = 1'b0;
    tick(5);
    check("t4_no_read", read_log.size(), 32'd0);
    check("t4_busy_drain", {31'd0, busy}, 32'd1);
    pop_log.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (pop_log.size() >= 2) break;
    end
    check("t4_pops", pop_log.size(), 32'd2);
    check("t4_busy_last", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t4_busy_after", {31'd0, busy}, 32'd0);
    check("t4_valid_after", {31'd0, m_valid}, 32'd0);
    check("t4_fifo_left", wr_ptr - rd_ptr, 32'd1);
    check("t4_no_read_end", read_log.size(), 32'd0);
    @(posedge clk); #1;

    // T6 wrap then reset mid-stream
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(W'($urandom));
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick(1);
    tick(2);
    @(negedge clk);
    check("t6_wrap", {28'd0, words_sent}, 32'd1);
    tick(1);
    m_ready = 1'b0;
    push(W'($urandom)); push(W'($urandom)); push(W'($urandom));
    tick(6);
    @(negedge clk);
    check("t6_buffered", {31'd0, m_valid}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_no_stale", {31'd0, m_valid}, 32'd0);
      tick(1);
    end

    // T7 random traffic
    for (int i = 0; i < 1500; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      enable  = ($urandom_range(0, 19) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && (wr_ptr - rd_ptr) < 16) push(W'($urandom));
      tick(1);
    end
    rst = 1'b0; enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) tick(1);
    check("t7_delivered", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
